// File: rtl/bsg_chip_pkg.sv
// Chip-level shared definitions: monitor tag-line encodings, monitor FSM
// states and global width parameters.
package bsg_chip_pkg;

  localparam int div_count_width_gp = 8;

  // mon.sel tag line encoding
  localparam logic [1:0] mon_sel_osc_gp  = 2'd0;
  localparam logic [1:0] mon_sel_dly_gp  = 2'd1;
  localparam logic [1:0] mon_sel_none_gp = 2'd2;

  typedef enum logic {
    MON_IDLE = 1'b0,
    MON_MEAS = 1'b1
  } mon_state_e;

endpackage

// File: rtl/bsg_chip_mon_sync.sv
// Multi-flop synchronizer for one asynchronous monitor input into clk_i.
module bsg_chip_mon_sync #(
  parameter int stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [stages_p-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < stages_p; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[stages_p-1];

endmodule

// File: rtl/bsg_chip_mon_period.sv
// Period monitor: measures the rising-edge-to-rising-edge period of the
// selected oscillator or delay-line output in clk_i cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   MON_IDLE | waiting for the first rising edge of the source
//   MON_MEAS | counting cycles since the last rising edge
module bsg_chip_mon_period
  import bsg_chip_pkg::*;
#(
  parameter int count_width_p = div_count_width_gp,
  parameter int sync_stages_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     osc_i,
  input  logic                     dly_i,
  input  logic [1:0]               sel_i,
  input  logic                     soft_reset_i,
  output logic [count_width_p-1:0] period_o,
  output logic                     overflow_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic                     drop_o
);

  localparam logic [count_width_p-1:0] cnt_max_lp = '1;
  localparam logic [count_width_p-1:0] cnt_one_lp = count_width_p'(1);

  logic osc_s, dly_s, src, src_q, edge_pulse, sel_chg, meas_done;
  logic [1:0] sel_q;
  mon_state_e state_q, state_d;
  logic [count_width_p-1:0] cnt_q, cnt_d, period_q, period_d, meas_val;
  logic sat_q, sat_d, v_q, v_d, ovf_q, ovf_d, drop_q, drop_d;

  bsg_chip_mon_sync #(.stages_p(sync_stages_p)) u_sync_osc (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .d_i(osc_i), .q_o(osc_s)
  );

  bsg_chip_mon_sync #(.stages_p(sync_stages_p)) u_sync_dly (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .d_i(dly_i), .q_o(dly_s)
  );

  always_comb begin
    src = 1'b0;
    if (sel_i == mon_sel_osc_gp)      src = osc_s;
    else if (sel_i == mon_sel_dly_gp) src = dly_s;
  end

  assign edge_pulse = src & ~src_q;
  assign sel_chg    = (sel_i != sel_q);
  // Once saturated the counter holds at max, so the result is max as well.
  assign meas_val   = sat_q ? cnt_max_lp : cnt_q + cnt_one_lp;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    period_d  = period_q;
    v_d       = v_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    meas_done = 1'b0;
    if (soft_reset_i) begin
      state_d = MON_IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
      v_d     = 1'b0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end else begin
      if (sel_chg) begin
        state_d = MON_IDLE;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end else if (edge_pulse) begin
        meas_done = (state_q == MON_MEAS);
        state_d   = MON_MEAS;
        cnt_d     = '0;
        sat_d     = 1'b0;
      end else if (state_q == MON_MEAS && !sat_q) begin
        cnt_d = cnt_q + cnt_one_lp;
        sat_d = (cnt_q == cnt_max_lp - cnt_one_lp);
      end
      if (meas_done) begin
        if (!v_q || yumi_i) begin
          period_d = meas_val;
          ovf_d    = sat_q;
          v_d      = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else if (yumi_i) begin
        v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= MON_IDLE;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      period_q <= '0;
      v_q      <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      sel_q    <= mon_sel_osc_gp;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      period_q <= period_d;
      v_q      <= v_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      sel_q    <= sel_i;
      src_q    <= src;
    end
  end

  assign period_o   = period_q;
  assign overflow_o = ovf_q;
  assign v_o        = v_q;
  assign drop_o     = drop_q;

endmodule
